// File: rtl/apb5_completer_mem.sv
// APB5 completer memory model: word-addressed RAM with per-word user bits, programmable
// wait states, error responses and a one-cycle protocol-violation pulse.
//
// state    | meaning
// S_IDLE   | no transfer; waiting for a setup phase (PSEL & !PENABLE)
// S_ACCESS | transfer latched; counting wait states, then completing on PSEL&PENABLE&PREADY
module apb5_completer_mem #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_WORDS       = 16,
    parameter int PROT_CHECK      = 1,
    parameter int WAKEUP_SUPPORT  = 1,
    parameter int USER_REQ_WIDTH  = 4,
    parameter int USER_DATA_WIDTH = 4,
    parameter int USER_RESP_WIDTH = 4,
    parameter int MAX_WAIT        = 15,
    localparam int WW             = $clog2(MAX_WAIT + 1)
) (
    input  logic                       PCLK,
    input  logic                       PRESET,
    input  logic                       PWAKEUP,
    input  logic                       PSEL,
    input  logic                       PENABLE,
    input  logic [ADDR_WIDTH-1:0]      PADDR,
    input  logic                       PWRITE,
    input  logic [DATA_WIDTH-1:0]      PWDATA,
    input  logic [DATA_WIDTH/8-1:0]    PSTRB,
    input  logic [2:0]                 PPROT,
    input  logic [USER_REQ_WIDTH-1:0]  PAUSER,
    input  logic [USER_DATA_WIDTH-1:0] PWUSER,
    output logic                       PREADY,
    output logic [DATA_WIDTH-1:0]      PRDATA,
    output logic                       PSLVERR,
    output logic [USER_DATA_WIDTH-1:0] PRUSER,
    output logic [USER_RESP_WIDTH-1:0] PBUSER,
    input  logic [WW-1:0]              wait_cfg,
    output logic                       protocol_err
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(NB);
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((1 << LSB) - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                     r_state;
    logic [ADDR_WIDTH-1:0]      r_addr;
    logic                       r_write;
    logic [DATA_WIDTH-1:0]      r_wdata;
    logic [NB-1:0]              r_strb;
    logic [2:0]                 r_prot;
    logic [USER_REQ_WIDTH-1:0]  r_auser;
    logic [USER_DATA_WIDTH-1:0] r_wuser;
    logic [WW-1:0]              r_cnt;

    logic                       r_pready;
    logic [DATA_WIDTH-1:0]      r_prdata;
    logic                       r_slverr;
    logic [USER_DATA_WIDTH-1:0] r_pruser;
    logic [USER_RESP_WIDTH-1:0] r_pbuser;
    logic                       r_perr;

    logic [DATA_WIDTH-1:0]      r_mem   [MEM_WORDS];
    logic [USER_DATA_WIDTH-1:0] r_muser [MEM_WORDS];

    logic                       w_idle;
    logic [ADDR_WIDTH-1:0]      w_addr_sel;
    logic                       w_write_sel;
    logic                       w_priv_sel;
    logic [USER_REQ_WIDTH-1:0]  w_auser_sel;
    logic [ADDR_WIDTH-1:0]      w_word;
    logic                       w_unaligned;
    logic                       w_oor;
    logic                       w_err;
    logic [DATA_WIDTH-1:0]      w_rdword;
    logic [USER_DATA_WIDTH-1:0] w_ruword;
    logic [WW-1:0]              w_wait;
    logic                       w_viol;
    logic [USER_RESP_WIDTH-1:0] w_buser;
    logic [DATA_WIDTH-1:0]      w_rdata_out;
    logic [USER_DATA_WIDTH-1:0] w_ruser_out;

    // With zero wait states the response is built in the setup cycle, so decode the live
    // bus in IDLE and the latched copy once in ACCESS.
    assign w_idle      = (r_state == S_IDLE);
    assign w_addr_sel  = w_idle ? PADDR    : r_addr;
    assign w_write_sel = w_idle ? PWRITE   : r_write;
    assign w_priv_sel  = w_idle ? PPROT[0] : r_prot[0];
    assign w_auser_sel = w_idle ? PAUSER   : r_auser;

    assign w_word      = w_addr_sel >> LSB;
    assign w_unaligned = |(w_addr_sel & LSB_MASK);
    assign w_oor       = 32'(w_word) >= 32'(MEM_WORDS);
    assign w_err       = w_unaligned || w_oor || ((PROT_CHECK != 0) && !w_priv_sel);
    assign w_buser     = USER_RESP_WIDTH'(w_auser_sel);

    always_comb begin
        w_rdword = '0;
        w_ruword = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (w_word == ADDR_WIDTH'(i)) begin
                w_rdword = r_mem[i];
                w_ruword = r_muser[i];
            end
        end
    end

    assign w_rdata_out = (!w_write_sel && !w_err) ? w_rdword : '0;
    assign w_ruser_out = (!w_write_sel && !w_err) ? w_ruword : '0;

    assign w_wait = (32'(wait_cfg) > 32'(MAX_WAIT)) ? WW'(MAX_WAIT) : wait_cfg;

    assign w_viol = !PSEL || (PADDR != r_addr) || (PWRITE != r_write) ||
                    (PWDATA != r_wdata) || (PSTRB != r_strb) || (PPROT != r_prot);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_prot   <= '0;
            r_auser  <= '0;
            r_wuser  <= '0;
            r_cnt    <= '0;
            r_pready <= 1'b0;
            r_prdata <= '0;
            r_slverr <= 1'b0;
            r_pruser <= '0;
            r_pbuser <= '0;
            r_perr   <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i]   <= '0;
                r_muser[i] <= '0;
            end
        end else begin
            r_perr <= (WAKEUP_SUPPORT != 0) && PSEL && !PWAKEUP;
            case (r_state)
                S_IDLE: begin
                    r_pready <= 1'b0;
                    r_prdata <= '0;
                    r_slverr <= 1'b0;
                    r_pruser <= '0;
                    r_pbuser <= '0;
                    if (PSEL && !PENABLE) begin
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_prot  <= PPROT;
                        r_auser <= PAUSER;
                        r_wuser <= PWUSER;
                        r_cnt   <= w_wait;
                        r_state <= S_ACCESS;
                        if (w_wait == '0) begin
                            r_pready <= 1'b1;
                            r_prdata <= w_rdata_out;
                            r_slverr <= w_err;
                            r_pruser <= w_ruser_out;
                            r_pbuser <= w_buser;
                        end
                    end else if (PENABLE) begin
                        r_perr <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (w_viol) begin
                        // Requester broke the transfer: abandon it without committing.
                        r_perr   <= 1'b1;
                        r_state  <= S_IDLE;
                        r_pready <= 1'b0;
                        r_prdata <= '0;
                        r_slverr <= 1'b0;
                        r_pruser <= '0;
                        r_pbuser <= '0;
                    end else if (r_pready) begin
                        if (PENABLE) begin
                            if (r_write && !w_err) begin
                                for (int i = 0; i < MEM_WORDS; i++) begin
                                    if (w_word == ADDR_WIDTH'(i)) begin
                                        for (int b = 0; b < NB; b++) begin
                                            if (r_strb[b]) begin
                                                r_mem[i][8*b +: 8] <= r_wdata[8*b +: 8];
                                            end
                                        end
                                        if (|r_strb) begin
                                            r_muser[i] <= r_wuser;
                                        end
                                    end
                                end
                            end
                            r_state  <= S_IDLE;
                            r_pready <= 1'b0;
                            r_prdata <= '0;
                            r_slverr <= 1'b0;
                            r_pruser <= '0;
                            r_pbuser <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - WW'(1);
                        if (r_cnt == WW'(1)) begin
                            r_pready <= 1'b1;
                            r_prdata <= w_rdata_out;
                            r_slverr <= w_err;
                            r_pruser <= w_ruser_out;
                            r_pbuser <= w_buser;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign PREADY       = r_pready;
    assign PRDATA       = r_prdata;
    assign PSLVERR      = r_slverr;
    assign PRUSER       = r_pruser;
    assign PBUSER       = r_pbuser;
    assign protocol_err = r_perr;

endmodule
